video_control_unit: RTL and testbench



---
 rtl/video_pkg.sv | 22 ++
 rtl/video_control_unit.sv | 156 +++++++++++++++
 tb/tb_video_control_unit.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared opcode, field and FSM-state definitions for the video processor execution stage.
package video_pkg;

    localparam logic [3:0] OP_SET_POS    = 4'b0000;
    localparam logic [3:0] OP_WR_MEM     = 4'b0001;
    localparam logic [3:0] OP_SET_OFFSET = 4'b0010;
    localparam logic [3:0] OP_WAIT_FRAME = 4'b0011;
    localparam logic [3:0] OP_NONE       = 4'b1111;

    localparam logic FIELD_POS    = 1'b0;
    localparam logic FIELD_OFFSET = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_REG     = 3'd1,
        ST_MEM_SETUP  = 3'd2,
        ST_MEM_WRITE  = 3'd3,
        ST_WAIT_FRAME = 3'd4,
        ST_DONE       = 3'd5
    } state_t;

endpackage

// File: rtl/video_control_unit.sv
// Execution stage behind the instruction decoder: register-bank writes, sprite-memory
// writes and end-of-frame waits, with a busy flag back to the decoder and a done pulse.
module video_control_unit
    import video_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_ADDR_W = 14,
    parameter int COLOR_W    = 9,
    parameter int MEM_WAIT   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            in_opcode,
    input  logic [13:0]           in_register,
    input  logic [31:0]           in_data,
    input  logic                  screen_done,
    output logic                  new_instruction,
    output logic                  done,
    output logic                  regbank_wr_en,
    output logic                  regbank_field,
    output logic [REG_ADDR_W-1:0] regbank_addr,
    output logic [31:0]           regbank_wr_data,
    output logic                  mem_wr_en,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [COLOR_W-1:0]    mem_wr_data,
    output logic [2:0]            dbg_state_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t                state_q, state_d;
    logic [13:0]           reg_q, reg_d;
    logic [31:0]           data_q, data_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  new_instr_q, new_instr_d;
    logic                  done_q, done_d;
    logic                  rb_wr_en_q, rb_wr_en_d;
    logic                  rb_field_q, rb_field_d;
    logic [REG_ADDR_W-1:0] rb_addr_q, rb_addr_d;
    logic [31:0]           rb_data_q, rb_data_d;
    logic                  mem_wr_en_q, mem_wr_en_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [COLOR_W-1:0]    mem_data_q, mem_data_d;

    // Every output register is loaded from the state being entered, so each
    // output is valid for exactly the cycles the FSM spends in its driving state.
    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        rb_field_d = rb_field_q;
        rb_addr_d  = rb_addr_q;
        rb_data_d  = rb_data_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;

        case (state_q)
            ST_IDLE: begin
                if (in_opcode == OP_SET_POS || in_opcode == OP_WR_MEM ||
                    in_opcode == OP_SET_OFFSET || in_opcode == OP_WAIT_FRAME) begin
                    reg_d  = in_register;
                    data_d = in_data;
                end
                case (in_opcode)
                    OP_SET_POS: begin
                        state_d    = ST_WR_REG;
                        rb_field_d = FIELD_POS;
                    end
                    OP_SET_OFFSET: begin
                        state_d    = ST_WR_REG;
                        rb_field_d = FIELD_OFFSET;
                    end
                    OP_WR_MEM:     state_d = ST_MEM_SETUP;
                    OP_WAIT_FRAME: state_d = ST_WAIT_FRAME;
                    default:       state_d = ST_IDLE;
                endcase
            end
            ST_WR_REG: state_d = ST_DONE;
            ST_MEM_SETUP: begin
                cnt_d   = WAIT_LOAD;
                state_d = ST_MEM_WRITE;
            end
            ST_MEM_WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_WAIT_FRAME: begin
                if (screen_done) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_WR_REG) begin
            rb_addr_d = reg_d[REG_ADDR_W-1:0];
            rb_data_d = data_d;
        end
        if (state_d == ST_MEM_SETUP) begin
            mem_addr_d = reg_d[MEM_ADDR_W-1:0];
            mem_data_d = data_d[COLOR_W-1:0];
        end

        new_instr_d = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        rb_wr_en_d  = (state_d == ST_WR_REG);
        mem_wr_en_d = (state_d == ST_MEM_WRITE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            reg_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            new_instr_q <= 1'b0;
            done_q      <= 1'b0;
            rb_wr_en_q  <= 1'b0;
            rb_field_q  <= 1'b0;
            rb_addr_q   <= '0;
            rb_data_q   <= '0;
            mem_wr_en_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            new_instr_q <= new_instr_d;
            done_q      <= done_d;
            rb_wr_en_q  <= rb_wr_en_d;
            rb_field_q  <= rb_field_d;
            rb_addr_q   <= rb_addr_d;
            rb_data_q   <= rb_data_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
        end
    end

    assign new_instruction = new_instr_q;
    assign done            = done_q;
    assign regbank_wr_en   = rb_wr_en_q;
    assign regbank_field   = rb_field_q;
    assign regbank_addr    = rb_addr_q;
    assign regbank_wr_data = rb_data_q;
    assign mem_wr_en       = mem_wr_en_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wr_data     = mem_data_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_video_control_unit.sv
// Directed bench for video_control_unit: register writes, memory writes, frame waits,
// busy-time opcode rejection and mid-instruction reset.
module tb_video_control_unit;
    import video_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_opcode;
    logic [13:0] in_register;
    logic [31:0] in_data;
    logic        screen_done;
    logic        new_instruction;
    logic        done;
    logic        regbank_wr_en;
    logic        regbank_field;
    logic [4:0]  regbank_addr;
    logic [31:0] regbank_wr_data;
    logic        mem_wr_en;
    logic [13:0] mem_addr;
    logic [8:0]  mem_wr_data;
    logic [2:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    video_control_unit #(
        .REG_ADDR_W(5), .MEM_ADDR_W(14), .COLOR_W(9), .MEM_WAIT(2)
    ) dut (
        .clk(clk), .reset(reset),
        .in_opcode(in_opcode), .in_register(in_register), .in_data(in_data),
        .screen_done(screen_done),
        .new_instruction(new_instruction), .done(done),
        .regbank_wr_en(regbank_wr_en), .regbank_field(regbank_field),
        .regbank_addr(regbank_addr), .regbank_wr_data(regbank_wr_data),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b1;
        in_opcode   = OP_SET_POS;
        in_register = 14'd3;
        in_data     = 32'h1234_5678;
        screen_done = 1'b0;

        // Reset held with a valid opcode present.
        tick(); tick(); tick();
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("rst_busy", 64'(new_instruction), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rbwe", 64'(regbank_wr_en), 64'd0);
        chk("rst_memwe", 64'(mem_wr_en), 64'd0);
        chk("rst_rbdata", 64'(regbank_wr_data), 64'd0);
        chk("rst_maddr", 64'(mem_addr), 64'd0);
        reset     = 1'b0;
        in_opcode = OP_NONE;
        tick();
        chk("idle_none", 64'(new_instruction), 64'd0);

        // Unused opcode is ignored.
        in_opcode = 4'b0100;
        tick();
        in_opcode = OP_NONE;
        chk("bad_op_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("bad_op_busy", 64'(new_instruction), 64'd0);

        // Position write.
        in_opcode   = OP_SET_POS;
        in_register = 14'd7;
        in_data     = 32'h0064_0032;
        tick();
        in_opcode = OP_NONE;
        chk("pos_busy", 64'(new_instruction), 64'd1);
        chk("pos_we", 64'(regbank_wr_en), 64'd1);
        chk("pos_field", 64'(regbank_field), 64'd0);
        chk("pos_addr", 64'(regbank_addr), 64'd7);
        chk("pos_data", 64'(regbank_wr_data), 64'h0064_0032);
        chk("pos_done0", 64'(done), 64'd0);
        tick();
        chk("pos_we_off", 64'(regbank_wr_en), 64'd0);
        chk("pos_done", 64'(done), 64'd1);
        chk("pos_busy2", 64'(new_instruction), 64'd1);
        tick();
        chk("pos_busy_off", 64'(new_instruction), 64'd0);
        chk("pos_done_off", 64'(done), 64'd0);
        chk("pos_data_hold", 64'(regbank_wr_data), 64'h0064_0032);

        // Sprite-memory write; upper data bits must be dropped.
        in_opcode   = OP_WR_MEM;
        in_register = 14'h1ABC;
        in_data     = 32'hABCD_E1FF;
        tick();
        in_opcode = OP_NONE;
        chk("mem_setup_state", 64'(dbg_state), 64'(ST_MEM_SETUP));
        chk("mem_setup_we", 64'(mem_wr_en), 64'd0);
        chk("mem_setup_busy", 64'(new_instruction), 64'd1);
        chk("mem_addr", 64'(mem_addr), 64'h1ABC);
        chk("mem_data", 64'(mem_wr_data), 64'h1FF);
        tick();
        chk("mem_we1", 64'(mem_wr_en), 64'd1);
        chk("mem_done_early1", 64'(done), 64'd0);
        tick();
        chk("mem_we2", 64'(mem_wr_en), 64'd1);
        chk("mem_addr_hold", 64'(mem_addr), 64'h1ABC);
        chk("mem_done_early2", 64'(done), 64'd0);
        tick();
        chk("mem_we_off", 64'(mem_wr_en), 64'd0);
        chk("mem_done", 64'(done), 64'd1);
        chk("mem_rbwe_quiet", 64'(regbank_wr_en), 64'd0);
        tick();
        chk("mem_busy_off", 64'(new_instruction), 64'd0);

        // Frame wait; screen_done in the acceptance cycle must not retire it.
        in_opcode   = OP_WAIT_FRAME;
        screen_done = 1'b1;
        tick();
        in_opcode   = OP_NONE;
        screen_done = 1'b0;
        chk("wf_state", 64'(dbg_state), 64'(ST_WAIT_FRAME));
        chk("wf_done_accept", 64'(done), 64'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("wf_busy", 64'(new_instruction), 64'd1);
            chk("wf_no_done", 64'(done), 64'd0);
        end
        screen_done = 1'b1;
        tick();
        screen_done = 1'b0;
        chk("wf_done", 64'(done), 64'd1);
        chk("wf_busy_done", 64'(new_instruction), 64'd1);
        tick();
        chk("wf_done_off", 64'(done), 64'd0);
        chk("wf_busy_off", 64'(new_instruction), 64'd0);

        // Offset write with a new opcode injected while busy.
        in_opcode   = OP_SET_OFFSET;
        in_register = 14'h3FE3;
        in_data     = 32'hDEAD_BEEF;
        tick();
        in_opcode   = OP_SET_POS;
        in_register = 14'd9;
        in_data     = 32'h0000_0001;
        chk("off_we", 64'(regbank_wr_en), 64'd1);
        chk("off_field", 64'(regbank_field), 64'd1);
        chk("off_addr", 64'(regbank_addr), 64'd3);
        chk("off_data", 64'(regbank_wr_data), 64'hDEAD_BEEF);
        tick();
        chk("off_done", 64'(done), 64'd1);
        chk("off_we_off", 64'(regbank_wr_en), 64'd0);
        in_opcode = OP_NONE;
        tick();
        chk("off_done_once", 64'(done), 64'd0);
        chk("off_no_second_we", 64'(regbank_wr_en), 64'd0);
        chk("off_idle", 64'(dbg_state), 64'(ST_IDLE));
        chk("off_addr_hold", 64'(regbank_addr), 64'd3);
        chk("off_field_hold", 64'(regbank_field), 64'd1);
        tick();
        chk("off_idle2_done", 64'(done), 64'd0);

        // Reset during MEM_WRITE aborts the instruction.
        in_opcode   = OP_WR_MEM;
        in_register = 14'h0123;
        in_data     = 32'h0000_0055;
        tick();
        in_opcode = OP_NONE;
        tick();
        chk("abort_we_before", 64'(mem_wr_en), 64'd1);
        reset = 1'b1;
        tick();
        chk("abort_we", 64'(mem_wr_en), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_busy", 64'(new_instruction), 64'd0);
        chk("abort_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("abort_maddr", 64'(mem_addr), 64'd0);
        reset = 1'b0;
        tick();
        chk("abort_no_done", 64'(done), 64'd0);
        chk("abort_no_we", 64'(mem_wr_en), 64'd0);

        // Normal instruction after the abort.
        in_opcode   = OP_SET_POS;
        in_register = 14'd5;
        in_data     = 32'h0000_0011;
        tick();
        in_opcode = OP_NONE;
        chk("post_we", 64'(regbank_wr_en), 64'd1);
        chk("post_addr", 64'(regbank_addr), 64'd5);
        chk("post_data", 64'(regbank_wr_data), 64'h11);
        tick();
        chk("post_done", 64'(done), 64'd1);
        tick();
        chk("post_busy_off", 64'(new_instruction), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
